mem_access_arbiter: RTL and testbench

Two-port access arbiter and sequencer in front of the single-port data-space `memory_map`. It shares the unit between the stack/interrupt unit (port 0) and the core load/store unit (port 1). It holds the memory-map inputs stable for the region-dependent access latency (register/IO region: 1 cycle; SRAM region: 3 cycles) and returns read data with a per-port completion pulse.

---
 rtl/mem_access_arbiter.sv | 82 ++++++++
 tb/tb_mem_access_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin two-port sequencer for memory_map; r0/r1 req/we/addr/wdata/io_only in, gnt/done out, mm_* drive the map, mm_q captured into rdata
module mem_access_arbiter #(
  parameter int unsigned LAT_REG = 1,
  parameter int unsigned LAT_SRAM = 3,
  parameter logic [15:0] REG_TOP = 16'h005F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  input  logic        r0_io_only,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  input  logic        r1_io_only,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_done,
  output logic        r1_done,
  output logic [7:0]  rdata,
  output logic [15:0] mm_addr,
  output logic        mm_we,
  output logic [7:0]  mm_data_in,
  output logic        mm_io_only,
  input  logic [7:0]  mm_q
);
  localparam int CW = $clog2(LAT_SRAM + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic last, owner, win, accept, complete, w_we, w_io;
  logic [15:0] w_addr;
  logic [7:0] w_wdata;
  logic [CW-1:0] cnt, cnt_n, lat;
  always_comb begin
    win = (r0_req & r1_req) ? ~last : r1_req;
    complete = (state == BUSY) && (cnt == '0);
    accept = (r0_req | r1_req) && ((state == IDLE) || complete);
    w_addr = win ? r1_addr : r0_addr;
    w_wdata = win ? r1_wdata : r0_wdata;
    w_we = win ? r1_we : r0_we;
    w_io = win ? r1_io_only : r0_io_only;
    lat = (w_io || (w_addr <= REG_TOP)) ? CW'(LAT_REG) : CW'(LAT_SRAM);
    state_n = accept ? BUSY : complete ? IDLE : state;
    cnt_n = accept ? lat : cnt - CW'(cnt != '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      owner <= 1'b0;
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      rdata <= '0;
      mm_addr <= '0;
      mm_we <= 1'b0;
      mm_data_in <= '0;
      mm_io_only <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mm_we <= accept & w_we;
      r0_gnt <= accept & ~win;
      r1_gnt <= accept & win;
      r0_done <= complete & ~owner;
      r1_done <= complete & owner;
      if (complete) rdata <= mm_q;
      if (accept) begin
        mm_addr <= w_addr;
        mm_data_in <= w_wdata;
        mm_io_only <= w_io;
        owner <= win;
        last <= win;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: scoreboard bench for mem_access_arbiter with a simple memory_map model
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic r0_req, r0_we, r0_io_only, r1_req, r1_we, r1_io_only;
  logic [15:0] r0_addr, r1_addr, mm_addr;
  logic [7:0] r0_wdata, r1_wdata, rdata, mm_data_in, mm_q;
  logic r0_gnt, r1_gnt, r0_done, r1_done, mm_we, mm_io_only;
  logic [7:0] mem [65536];
  typedef struct {logic port; logic rd; logic [7:0] data; int lat;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  int gnt_cyc [2];
  logic b2b = 1'b0, b2b_prev = 1'b0;
  int b2b_n = 0;
  mem_access_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_io_only(r0_io_only),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_io_only(r1_io_only),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done), .rdata(rdata),
    .mm_addr(mm_addr), .mm_we(mm_we), .mm_data_in(mm_data_in), .mm_io_only(mm_io_only), .mm_q(mm_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk)
    if (reset) mem[16'h0010] <= 8'h3C;
    else if (mm_we) mem[mm_addr] <= mm_data_in;
  assign mm_q = mem[mm_addr];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (r0_done || r1_done) begin
      if (q.size() == 0) chk("unexpected_done", 32'(r1_done) + 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("done_port", 32'(r1_done), 32'(e.port));
        if (e.rd) chk("rdata", 32'(rdata), 32'(e.data));
        chk("latency", 32'(cyc - gnt_cyc[e.port]), 32'(e.lat + 1));
      end
    end
    if (r0_gnt || r1_gnt) begin
      chk("gnt_onehot", 32'(r0_gnt & r1_gnt), 32'd0);
      if (b2b) begin
        if (b2b_n > 0) begin
          chk("b2b_gnt_on_done", 32'(r0_done | r1_done), 32'd1);
          chk("b2b_alternate", 32'(r1_gnt), 32'(!b2b_prev));
        end
        b2b_prev = r1_gnt;
        b2b_n++;
      end
      if (r0_gnt) gnt_cyc[0] = cyc;
      if (r1_gnt) gnt_cyc[1] = cyc;
    end
  end
  task automatic drive(input logic p, input logic req, input logic we, input logic io,
                       input logic [15:0] addr, input logic [7:0] wd);
    if (p) begin
      r1_req = req; r1_we = we; r1_io_only = io; r1_addr = addr; r1_wdata = wd;
    end else begin
      r0_req = req; r0_we = we; r0_io_only = io; r0_addr = addr; r0_wdata = wd;
    end
  endtask
  task automatic wait_gnt(input logic p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? r1_gnt : r0_gnt) && n < 50);
    chk("gnt_seen", 32'(p ? r1_gnt : r0_gnt), 32'd1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask
  task automatic access(input logic p, input logic we, input logic io, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd_want, input int lat);
    q.push_back('{p, !we, rd_want, lat});
    drive(p, 1'b1, we, io, addr, wd);
    wait_gnt(p);
    drive(p, 1'b0, we, io, addr, wd);
    for (int i = 0; i < lat; i++) begin
      if (i > 0) @(negedge clk);
      chk("mm_addr_hold", 32'(mm_addr), 32'(addr));
      chk("mm_data_hold", 32'(mm_data_in), 32'(wd));
      chk("mm_io_hold", 32'(mm_io_only), 32'(io));
      chk("mm_we_pulse", 32'(mm_we), 32'(we && i == 0));
    end
    @(negedge clk);
    chk("mm_we_off", 32'(mm_we), 32'd0);
    wait_done();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    q.push_back('{1'b0, 1'b1, 8'h3C, 1});
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
      chk("rst_done", 32'({r0_done, r1_done}), 32'd0);
      chk("rst_mm_addr", 32'(mm_addr), 32'd0);
      chk("rst_mm_we", 32'(mm_we), 32'd0);
      chk("rst_mm_data", 32'(mm_data_in), 32'd0);
      chk("rst_mm_io", 32'(mm_io_only), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_gnt_r0", 32'(r0_gnt), 32'd1);
    chk("first_gnt_r1", 32'(r1_gnt), 32'd0);
    r0_req = 1'b0;
    r1_req = 1'b0;
    wait_done();
    access(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, 8'h3C, 1);
    access(1'b1, 1'b1, 1'b0, 16'h0100, 8'hA5, 8'h00, 3);
    access(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00, 8'hA5, 3);
    access(1'b0, 1'b1, 1'b1, 16'h003F, 8'h80, 8'h00, 1);
    access(1'b0, 1'b0, 1'b1, 16'h003F, 8'h00, 8'h80, 1);
    access(1'b0, 1'b0, 1'b0, 16'h005F, 8'h00, 8'h00, 1);
    access(1'b1, 1'b0, 1'b0, 16'h0060, 8'h00, 8'h00, 3);
    access(1'b1, 1'b0, 1'b0, 16'h0900, 8'h00, 8'h00, 3);
    b2b = 1'b1;
    b2b_n = 0;
    repeat (2) begin
      q.push_back('{1'b0, 1'b1, 8'h3C, 1});
      q.push_back('{1'b1, 1'b1, 8'hA5, 3});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    begin
      int n = 0, g = 0;
      while (g < 4 && n < 100) begin
        @(negedge clk);
        n++;
        if (r0_gnt || r1_gnt) g++;
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      chk("contention_grants", 32'(g), 32'd4);
    end
    wait_done();
    b2b = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    wait_gnt(1'b1);
    r1_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mm_we", 32'(mm_we), 32'd0);
    chk("midrst_done", 32'({r0_done, r1_done}), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    chk("midrst_mm_addr", 32'(mm_addr), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    access(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00, 8'hA5, 3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
